// File: rtl/coherence_bus_ctrl.sv
// Memory-side bus controller for two snooping cores: arbitrates I/D requests,
// drives snoops into the other core's dcache and owns the single RAM port.
module coherence_bus_ctrl #(
   parameter int CPUS   = 2,
   parameter int WORD_W = 32
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [CPUS-1:0]          iREN,
   input  logic [CPUS*WORD_W-1:0]   iaddr,
   input  logic [CPUS-1:0]          dREN,
   input  logic [CPUS-1:0]          dWEN,
   input  logic [CPUS*WORD_W-1:0]   daddr,
   input  logic [CPUS*WORD_W-1:0]   dstore,
   input  logic [CPUS-1:0]          cctrans,
   input  logic [CPUS-1:0]          ccwrite,
   output logic [CPUS-1:0]          iwait,
   output logic [CPUS-1:0]          dwait,
   output logic [CPUS*WORD_W-1:0]   iload,
   output logic [CPUS*WORD_W-1:0]   dload,
   output logic [CPUS-1:0]          ccwait,
   output logic [CPUS-1:0]          ccinv,
   output logic [CPUS*WORD_W-1:0]   ccsnoopaddr,
   output logic                     ramREN,
   output logic                     ramWEN,
   output logic [WORD_W-1:0]        ramaddr,
   output logic [WORD_W-1:0]        ramstore,
   input  logic [WORD_W-1:0]        ramload,
   input  logic [1:0]               ramstate
);

   localparam logic [1:0] RAM_ACCESS = 2'd2;

   typedef enum logic [1:0] {CL_NONE, CL_IF, CL_COH, CL_WB} cls_e;
   typedef enum logic [2:0] {IDLE, WRITE, IFETCH, SNOOP, C2C, MEMRD, UPGR} state_e;

   state_e state;
   logic   r;        // granted requester
   logic   s;        // snooper, always the other core
   logic   rr;       // core favoured on a class tie
   logic   rd_q;     // coherence request also wants the data word
   cls_e   cls [CPUS];
   logic   win;
   logic   los;
   cls_e   win_cls;
   logic   quiet;
   logic   access;

   function automatic logic [WORD_W-1:0] word(input logic [CPUS*WORD_W-1:0] v, input logic c);
      return v[c*WORD_W +: WORD_W];
   endfunction

   assign s      = ~r;
   assign los    = ~win;
   assign access = (ramstate == RAM_ACCESS);
   // Hold off arbitration during a completion pulse so the requester can drop its request.
   assign quiet  = &iwait && &dwait;

   always_comb begin
      for (int c = 0; c < CPUS; c++) begin
         // NOTE: every path assigns cls[c], so no latch is inferred.
         if (dWEN[c] && !cctrans[c])       cls[c] = CL_WB;
         else if (cctrans[c] && !ccwait[c]) cls[c] = CL_COH;
         else if (iREN[c])                 cls[c] = CL_IF;
         else                              cls[c] = CL_NONE;
      end
   end

   assign win     = (cls[1] > cls[0]) ? 1'b1 : (cls[0] > cls[1]) ? 1'b0 : rr;
   assign win_cls = win ? cls[1] : cls[0];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         r           <= 1'b0;
         rr          <= 1'b0;
         rd_q        <= 1'b0;
         iwait       <= '1;
         dwait       <= '1;
         iload       <= '0;
         dload       <= '0;
         ccwait      <= '0;
         ccinv       <= '0;
         ccsnoopaddr <= '0;
         ramREN      <= 1'b0;
         ramWEN      <= 1'b0;
         ramaddr     <= '0;
         ramstore    <= '0;
      end else begin
         // NOTE: later nonblocking writes in this block override these defaults, giving one-cycle pulses.
         iwait <= '1;
         dwait <= '1;
         case (state)
            IDLE: begin
               if (quiet && win_cls != CL_NONE) begin
                  r <= win;
                  case (win_cls)
                     CL_WB: begin
                        state    <= WRITE;
                        ramWEN   <= 1'b1;
                        ramaddr  <= word(daddr, win);
                        ramstore <= word(dstore, win);
                     end
                     CL_COH: begin
                        state  <= SNOOP;
                        rd_q   <= dREN[win];
                        ccwait[los] <= 1'b1;
                        ccinv[los]  <= ccwrite[win];
                        ccsnoopaddr[los*WORD_W +: WORD_W] <= word(daddr, win);
                     end
                     default: begin
                        state   <= IFETCH;
                        ramREN  <= 1'b1;
                        ramaddr <= word(iaddr, win);
                     end
                  endcase
               end
            end
            WRITE: begin
               if (access) begin
                  ramWEN   <= 1'b0;
                  dwait[r] <= 1'b0;
                  rr       <= s;
                  state    <= IDLE;
               end
            end
            IFETCH: begin
               if (access) begin
                  ramREN   <= 1'b0;
                  iwait[r] <= 1'b0;
                  iload[r*WORD_W +: WORD_W] <= ramload;
                  rr       <= s;
                  state    <= IDLE;
               end
            end
            SNOOP: begin
               if (cctrans[s]) begin
                  ccinv <= '0;
                  if (ccwrite[s]) begin
                     // Snooper owns the line dirty: its write-back doubles as the data source.
                     state    <= C2C;
                     ramWEN   <= 1'b1;
                     ramaddr  <= word(daddr, s);
                     ramstore <= word(dstore, s);
                  end else if (rd_q) begin
                     state   <= MEMRD;
                     ramREN  <= 1'b1;
                     ramaddr <= word(ccsnoopaddr, s);
                  end else begin
                     state    <= UPGR;
                     ccwait   <= '0;
                     dwait[r] <= 1'b0;
                  end
               end
            end
            C2C: begin
               if (access) begin
                  ramWEN <= 1'b0;
                  ccwait <= '0;
                  dwait  <= '0;
                  dload[r*WORD_W +: WORD_W] <= ramstore;
                  rr     <= s;
                  state  <= IDLE;
               end
            end
            MEMRD: begin
               if (access) begin
                  ramREN   <= 1'b0;
                  ccwait   <= '0;
                  dwait[r] <= 1'b0;
                  dload[r*WORD_W +: WORD_W] <= ramload;
                  rr       <= s;
                  state    <= IDLE;
               end
            end
            UPGR: begin
               rr    <= s;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Self-checking bench for coherence_bus_ctrl: directed table, multi-cycle
// corner sequences and random transactions against a word-level memory model.
module tb_coherence_bus_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [1:0]  iREN, dREN, dWEN, cctrans, ccwrite;
   logic [63:0] iaddr, daddr, dstore;
   logic [1:0]  iwait, dwait, ccwait, ccinv;
   logic [63:0] iload, dload, ccsnoopaddr;
   logic        ramREN, ramWEN;
   logic [31:0] ramaddr, ramstore, ramload;
   logic [1:0]  ramstate;

   coherence_bus_ctrl dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
      .daddr(daddr), .dstore(dstore), .cctrans(cctrans), .ccwrite(ccwrite),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .ccwait(ccwait),
      .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
      .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- RAM model and reference memory ----------------
   logic [31:0] ram_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   int ram_lat = 0;
   int ram_cnt = 0;
   bit ram_err = 0;

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return {16'hA5A5, a[15:0]};
   endfunction

   function automatic logic [31:0] ram_rd(input logic [31:0] a);
      return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   initial begin
      ramstate = 2'd0;
      ramload  = 32'h0;
   end

   always @(negedge CLK) begin
      if (ramREN || ramWEN) begin
         if (ram_cnt >= ram_lat) begin
            ramstate = 2'd2;
            ramload  = ram_rd(ramaddr);
            if (ramWEN) ram_mem[ramaddr] = ramstore;
            ram_cnt  = 0;
         end else begin
            ramstate = ram_err ? 2'd3 : 2'd1;
            ramload  = 32'hBAD0BAD0;
            ram_cnt++;
         end
      end else begin
         ramstate = 2'd0;
         ram_cnt  = 0;
      end
   end

   // ---------------- transactions ----------------
   typedef enum logic [2:0] {K_IF, K_WB, K_RD, K_RDX, K_UPG} kind_e;
   typedef struct {
      kind_e       kind;
      logic        r;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        mod;      // snooper holds the line Modified
      logic [31:0] sdata;    // snooper's dirty word
      int          lat;
      bit          err;
      logic [31:0] exp_data;
      logic        exp_inv;
      int          exp_ram;
   } vec_t;

   function automatic vec_t mk(kind_e k, logic r, logic [31:0] a, logic [31:0] wd, logic m,
                               logic [31:0] sd, int lat, bit err, logic [31:0] ed, logic ei, int er);
      vec_t v;
      v.kind = k; v.r = r; v.addr = a; v.wdata = wd; v.mod = m; v.sdata = sd;
      v.lat = lat; v.err = err; v.exp_data = ed; v.exp_inv = ei; v.exp_ram = er;
      return v;
   endfunction

   // Word-level effect of one transaction on memory and on what the requester receives.
   task automatic model(input vec_t t, output logic [31:0] d, output logic inv, output int nram);
      inv  = (t.kind == K_RDX || t.kind == K_UPG);
      nram = (t.kind == K_UPG) ? 0 : t.lat + 1;
      d    = 32'h0;
      case (t.kind)
         K_IF: d = ref_rd(t.addr);
         K_WB: ref_mem[t.addr] = t.wdata;
         K_RD, K_RDX: begin
            if (t.mod) begin
               d = t.sdata;
               ref_mem[t.addr] = t.sdata;
            end else begin
               d = ref_rd(t.addr);
            end
         end
         default: ;
      endcase
   endtask

   task automatic clear_inputs();
      iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
      iaddr = '0; daddr = '0; dstore = '0;
   endtask

   task automatic run_txn(input vec_t t, input logic [31:0] exp_d, input logic exp_inv,
                          input int exp_ram, input string name);
      int ri, si, ramcyc, snoop_cyc, both_hi, self_snoop;
      bit done, acked, inv_seen, other_low, coh;
      logic [31:0] got, snaddr;
      ri = t.r; si = 1 - ri;
      ramcyc = 0; snoop_cyc = 0; both_hi = 0; self_snoop = 0;
      done = 0; acked = 0; inv_seen = 0; other_low = 0;
      got = 0; snaddr = 0;
      coh = (t.kind == K_RD || t.kind == K_RDX || t.kind == K_UPG);
      ram_lat = t.lat; ram_err = t.err;
      case (t.kind)
         K_IF: begin iREN[ri] = 1'b1; iaddr[ri*32 +: 32] = t.addr; end
         K_WB: begin dWEN[ri] = 1'b1; daddr[ri*32 +: 32] = t.addr; dstore[ri*32 +: 32] = t.wdata; end
         default: begin
            cctrans[ri] = 1'b1;
            ccwrite[ri] = (t.kind != K_RD);
            dREN[ri]    = (t.kind != K_UPG);
            daddr[ri*32 +: 32] = t.addr;
         end
      endcase
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         @(negedge CLK);
         if (ramREN && ramWEN) both_hi++;
         if (ramREN || ramWEN) ramcyc++;
         if (ccwait[ri]) self_snoop++;
         if (ccwait[si]) begin
            snoop_cyc++;
            snaddr = ccsnoopaddr[si*32 +: 32];
            inv_seen |= ccinv[si];
            if (snoop_cyc == 2 && !acked) begin
               acked = 1;
               cctrans[si] = 1'b1;
               ccwrite[si] = t.mod;
               daddr[si*32 +: 32]  = t.addr;
               dstore[si*32 +: 32] = t.sdata;
            end
         end
         if (t.kind == K_IF ? !iwait[ri] : !dwait[ri]) begin
            done = 1;
            got = (t.kind == K_IF) ? iload[ri*32 +: 32] : dload[ri*32 +: 32];
            other_low = !dwait[si] || !iwait[si];
         end
      end
      clear_inputs();
      check({name, " done"}, done, 1);
      if (t.kind == K_IF || t.kind == K_RD || t.kind == K_RDX)
         check({name, " data"}, got, exp_d);
      check({name, " ram cycles"}, ramcyc, exp_ram);
      check({name, " ren&wen"}, both_hi, 0);
      check({name, " requester snooped"}, self_snoop, 0);
      check({name, " other wait low"}, other_low, coh && t.mod);
      if (coh) begin
         check({name, " snoop addr"}, snaddr, t.addr);
         check({name, " ccinv"}, inv_seen, exp_inv);
      end else begin
         check({name, " no snoop"}, snoop_cyc, 0);
      end
      @(negedge CLK);
      check({name, " pulse width"}, {iwait, dwait, ccwait}, 6'b111100);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic wait_op(output bit ok);
      bit prev;
      prev = ramREN | ramWEN;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge CLK);
         if ((ramREN | ramWEN) && !prev) ok = 1;
         prev = ramREN | ramWEN;
      end
   endtask

   vec_t tbl [11];
   vec_t v;
   logic [31:0] ed;
   logic ei;
   int er;
   bit ok, found;
   int seen [$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      tbl[0]  = mk(K_WB,  0, 32'h040, 32'hDEADBEEF, 0, 32'h0,        1, 0, 32'h0,        0, 2);
      tbl[1]  = mk(K_IF,  0, 32'h040, 32'h0,        0, 32'h0,        2, 0, 32'hDEADBEEF, 0, 3);
      tbl[2]  = mk(K_IF,  1, 32'h044, 32'h0,        0, 32'h0,        0, 0, 32'hA5A50044, 0, 1);
      tbl[3]  = mk(K_RD,  1, 32'h100, 32'h0,        0, 32'h0,        1, 0, 32'hA5A50100, 0, 2);
      tbl[4]  = mk(K_RDX, 0, 32'h200, 32'h0,        1, 32'h12345678, 1, 0, 32'h12345678, 1, 2);
      tbl[5]  = mk(K_IF,  1, 32'h200, 32'h0,        0, 32'h0,        0, 0, 32'h12345678, 0, 1);
      tbl[6]  = mk(K_UPG, 0, 32'h300, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 0);
      tbl[7]  = mk(K_RD,  0, 32'h104, 32'h0,        1, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 0, 1);
      tbl[8]  = mk(K_RDX, 1, 32'h108, 32'h0,        0, 32'h0,        3, 1, 32'hA5A50108, 1, 4);
      tbl[9]  = mk(K_WB,  1, 32'h10C, 32'h0BADF00D, 0, 32'h0,        0, 0, 32'h0,        0, 1);
      tbl[10] = mk(K_IF,  0, 32'h10C, 32'h0,        0, 32'h0,        1, 1, 32'h0BADF00D, 0, 2);

      // Reset state
      repeat (2) @(negedge CLK);
      check("reset waits", {iwait, dwait}, 4'hF);
      check("reset snoop", {ccwait, ccinv}, 4'h0);
      check("reset ram req", {ramREN, ramWEN}, 2'b00);
      check("reset ram bus", {ramaddr, ramstore}, 64'h0);
      check("reset loads", iload | dload | ccsnoopaddr, 64'h0);
      RST = 1'b0;
      @(negedge CLK);

      // Directed table
      for (int i = 0; i < 11; i++) begin
         model(tbl[i], ed, ei, er);
         run_txn(tbl[i], tbl[i].exp_data, tbl[i].exp_inv, tbl[i].exp_ram, $sformatf("vec%0d", i));
      end

      // Reset while MEMRD waits on a RAM that never answers
      ram_lat = 100000; ram_err = 0;
      cctrans[1] = 1'b1; dREN[1] = 1'b1; daddr[63:32] = 32'h100;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge CLK);
         if (ccwait[0]) begin cctrans[0] = 1'b1; daddr[31:0] = 32'h100; end
         if (ramREN) found = 1;
      end
      check("rst-memrd reached", found, 1);
      RST = 1'b1;
      clear_inputs();
      @(negedge CLK);
      RST = 1'b0;
      check("rst-memrd ram req", {ramREN, ramWEN}, 2'b00);
      check("rst-memrd waits", {iwait, dwait}, 4'hF);
      check("rst-memrd snoop", {ccwait, ccinv}, 4'h0);
      v = mk(K_IF, 0, 32'h044, 0, 0, 0, 1, 0, 0, 0, 0);
      model(v, ed, ei, er);
      run_txn(v, ed, ei, er, "post-reset IF");

      // Round-robin with both cores fetching continuously
      do_reset();
      ram_lat = 0; ram_err = 0;
      iaddr = {32'h804, 32'h800};
      iREN = 2'b11;
      for (int i = 0; i < 60 && seen.size() < 4; i++) begin
         @(negedge CLK);
         if (!iwait[0]) begin
            seen.push_back(0);
            if (seen.size() == 1) check("rr first data", iload[31:0], ref_rd(32'h800));
         end
         if (!iwait[1]) seen.push_back(1);
      end
      check("rr deliveries", seen.size(), 4);
      for (int k = 0; k < seen.size(); k++) check($sformatf("rr grant%0d", k), seen[k], k % 2);

      // Core0 WB raised during a core1 fetch wins the next arbitration
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         wait_op(ok);
         if (ok && ramREN && ramaddr == 32'h804) found = 1;
      end
      check("prio1 core1 IF seen", found, 1);
      dWEN[0] = 1'b1; daddr[31:0] = 32'h900; dstore[31:0] = 32'h11112222;
      wait_op(ok);
      check("prio1 next op", {ok, ramWEN, ramREN, ramaddr, ramstore}, {3'b110, 32'h900, 32'h11112222});
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge CLK);
         if (!dwait[0]) found = 1;
      end
      check("prio1 wb done", found, 1);
      dWEN[0] = 1'b0;
      ref_mem[32'h900] = 32'h11112222;

      // Core0 WB beats core1's fetch even though round-robin now favours core1
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         wait_op(ok);
         if (ok && ramREN && ramaddr == 32'h800) found = 1;
      end
      check("prio2 core0 IF seen", found, 1);
      dWEN[0] = 1'b1; daddr[31:0] = 32'h904; dstore[31:0] = 32'h33334444;
      wait_op(ok);
      check("prio2 next op", {ok, ramWEN, ramREN, ramaddr}, {3'b110, 32'h904});
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge CLK);
         if (!dwait[0]) found = 1;
      end
      check("prio2 wb done", found, 1);
      clear_inputs();
      ref_mem[32'h904] = 32'h33334444;
      repeat (3) @(negedge CLK);

      // Random transactions against the word-level model
      for (int n = 0; n < 40; n++) begin
         v.kind  = kind_e'($urandom_range(0, 4));
         v.r     = 1'($urandom_range(0, 1));
         v.addr  = 32'h600 + 32'($urandom_range(0, 7)) * 4;
         v.wdata = $urandom;
         v.sdata = $urandom;
         v.mod   = (v.kind == K_RD || v.kind == K_RDX) ? 1'($urandom_range(0, 1)) : 1'b0;
         v.lat   = $urandom_range(0, 3);
         v.err   = 1'($urandom_range(0, 1));
         model(v, ed, ei, er);
         run_txn(v, ed, ei, er, $sformatf("rnd%0d", n));
      end

      // RAM contents must match the model exactly
      found = 0;
      foreach (ref_mem[a]) if (!ram_mem.exists(a) || ram_mem[a] !== ref_mem[a]) found = 1;
      check("ram size", ram_mem.num(), ref_mem.num());
      check("ram contents", found, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
